adder_vector_recorder: RTL and testbench

//  On-chip capture of stimulus/response vectors {a,b,cin,s,cout} from the adder datapath.

---
 rtl/adder_vector_recorder_if.sv | 49 ++++
 rtl/adder_vector_recorder.sv | 136 +++++++++++++
 tb/tb_adder_vector_recorder.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/adder_vector_recorder_if.sv
// Bundles the capture, drain and status signals of adder_vector_recorder.
//
// Parameters:
//   VEC_W   width of one packed vector {a,b,cin,s_exp,cout_exp}
//   ADDR_W  buffer pointer width; count is ADDR_W+1 bits so it can reach DEPTH
//
// Signals (direction seen from the recorder, i.e. the slave modport):
//   arm        in   start a capture session
//   stop       in   end capture early
//   cap_valid  in   cap_vec is valid this cycle
//   cap_vec    in   vector to record
//   out_valid  out  out_vec holds a buffered vector
//   out_ready  in   consumer accepts out_vec
//   out_vec    out  buffered vector, oldest first
//   out_last   out  out_vec is the final buffered vector
//   count      out  vectors captured in the current session
//   full       out  count == DEPTH
//   busy       out  recorder is not idle
//   overflow   out  sticky: a capture was lost while draining
//
// master: the side that drives stimulus and consumes the drained stream.
// slave:  the recorder itself.
interface adder_vector_recorder_if #(
  parameter int VEC_W  = 5,
  parameter int ADDR_W = 3
);
  logic              arm;
  logic              stop;
  logic              cap_valid;
  logic [VEC_W-1:0]  cap_vec;
  logic              out_valid;
  logic              out_ready;
  logic [VEC_W-1:0]  out_vec;
  logic              out_last;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              busy;
  logic              overflow;

  modport master (
    output arm, stop, cap_valid, cap_vec, out_ready,
    input  out_valid, out_vec, out_last, count, full, busy, overflow
  );

  modport slave (
    input  arm, stop, cap_valid, cap_vec, out_ready,
    output out_valid, out_vec, out_last, count, full, busy, overflow
  );
endinterface

// File: rtl/adder_vector_recorder.sv
// On-chip recorder for adder stimulus/response vectors {a,b,cin,s,cout}.
// Vectors are captured into a small register file during a session, then
// streamed out oldest-first over a valid/ready port. Each output word has the
// layout of one adder.tv line.
//
// Parameters:
//   VEC_W   vector width (5)
//   DEPTH   buffer entries, power of two >= 2 (8)
//   ADDR_W  pointer width, $clog2(DEPTH) (3)
//
// Ports:
//   clk  clock, all state changes on posedge
//   rst  synchronous active-high reset
//   bus  adder_vector_recorder_if.slave (capture inputs, drain stream, status)
//
// Optional feature macro: REC_DEDUP_EN
//   When defined, a capture equal to the previously written vector of the
//   same session is dropped. When undefined no compare logic exists.
module adder_vector_recorder #(
  parameter int VEC_W  = 5,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_vector_recorder_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CAPT, DRAIN} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  state_t             state;
  state_t             state_nxt;
  logic [VEC_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    count;
  logic               overflow;
  logic               wr_en;
  logic [ADDR_W:0]    count_after_wr;
  logic               out_valid;
  logic               out_last;
  logic               xfer;

  // Write qualification. With dedup, the last written vector sits just
  // behind wr_ptr, so no separate shadow register is needed.
  always_comb begin
    wr_en = 1'b0;
    if (state == CAPT && bus.cap_valid) begin
`ifdef REC_DEDUP_EN
      wr_en = (count == '0) || (bus.cap_vec != mem[wr_ptr - ADDR_W'(1)]);
`else
      wr_en = 1'b1;
`endif
    end
  end

  // A same-cycle capture counts before stop is evaluated.
  assign count_after_wr = count + {{ADDR_W{1'b0}}, wr_en};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.arm) state_nxt = CAPT;
      CAPT: begin
        if (count_after_wr == DEPTH_C)
          state_nxt = DRAIN;
        else if (bus.stop)
          state_nxt = (count_after_wr != '0) ? DRAIN : IDLE;
      end
      DRAIN:   if (xfer && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // count is never zero in DRAIN, so count-1 cannot wrap there.
  always_comb begin
    out_valid = (state == DRAIN);
    out_last  = out_valid && ({1'b0, rd_ptr} == (count - ONE_C));
    xfer      = out_valid && bus.out_ready;
  end

  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_vec   = mem[rd_ptr];
  assign bus.count     = count;
  assign bus.full      = (count == DEPTH_C);
  assign bus.busy      = (state != IDLE);
  assign bus.overflow  = overflow;

  // Pointers, count and overflow. count is left untouched after a session
  // so software can read how much was captured until the next arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        CAPT: begin
          rd_ptr <= '0;
          if (wr_en) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            count  <= count_after_wr;
          end
        end
        DRAIN: begin
          if (bus.cap_valid) overflow <= 1'b1;
          if (xfer) rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Buffer storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.cap_vec;
  end

endmodule

// File: tb/tb_adder_vector_recorder.sv
// Self-checking bench for adder_vector_recorder. A session model keeps the
// list of vectors the recorder should hold; at the end of each capture the
// expected drain words {vec,last} are queued and a negedge monitor pops and
// compares them on every transfer.
module tb_adder_vector_recorder;
  localparam int VEC_W  = 5;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;
`ifdef REC_DEDUP_EN
  localparam int DEDUP_EXP = 2;
`else
  localparam int DEDUP_EXP = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_vector_recorder_if #(.VEC_W(VEC_W), .ADDR_W(ADDR_W)) bus ();

  adder_vector_recorder #(.VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  logic [VEC_W:0]   sb[$];
  logic [VEC_W-1:0] stim_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic a, input logic s, input logic cv, input logic [VEC_W-1:0] v);
    bus.arm = a; bus.stop = s; bus.cap_valid = cv; bus.cap_vec = v;
    @(posedge clk); #1;
    bus.arm = 1'b0; bus.stop = 1'b0; bus.cap_valid = 1'b0;
  endtask

  // Runs one capture session over stim_q and queues the expected drain.
  task automatic capture_session(input bit stop_last, input int gap_max, output int n);
    logic [VEC_W-1:0] exp_q[$];
    bit stopped = 1'b0;
    bit keep;
    bit is_last;
    applyStimulus(1'b1, 1'b0, 1'b0, '0);
    checkOutput("arm_busy", 32'(bus.busy), 32'd1);
    checkOutput("arm_overflow_clr", 32'(bus.overflow), 32'd0);
    foreach (stim_q[i]) begin
      if (exp_q.size() == DEPTH) break;
      repeat ($urandom_range(0, gap_max)) applyStimulus(1'b0, 1'b0, 1'b0, VEC_W'($urandom));
      is_last = (i == stim_q.size() - 1);
`ifdef REC_DEDUP_EN
      keep = (exp_q.size() == 0) || (stim_q[i] != exp_q[$]);
`else
      keep = 1'b1;
`endif
      if (keep) exp_q.push_back(stim_q[i]);
      applyStimulus(1'b0, stop_last && is_last, 1'b1, stim_q[i]);
      if (stop_last && is_last) stopped = 1'b1;
    end
    if (!stopped && exp_q.size() < DEPTH) applyStimulus(1'b0, 1'b1, 1'b0, '0);
    foreach (exp_q[i]) sb.push_back({exp_q[i], i == exp_q.size() - 1});
    n = exp_q.size();
    checkOutput("cap_count", 32'(bus.count), 32'(n));
    checkOutput("cap_full", 32'(bus.full), 32'(n == DEPTH));
    checkOutput("cap_busy", 32'(bus.busy), 32'(n > 0));
  endtask

  task automatic drain(input bit random_ready, output int cycles);
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      bus.out_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    bus.out_ready = 1'b0;
    checkOutput("drain_done", 32'(bus.busy), 32'd0);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    checkOutput("idle_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  // Scoreboard monitor: every accepted word must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got 0x%0h, expected no transfer", {bus.out_vec, bus.out_last});
      end else begin
        checkOutput("out_word", 32'({bus.out_vec, bus.out_last}), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    int n;
    int cyc;
    int len;
    bus.arm = 1'b0; bus.stop = 1'b0; bus.cap_valid = 1'b0;
    bus.cap_vec = '0; bus.out_ready = 1'b0;

    $display("[TB] reset");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_overflow", 32'(bus.overflow), 32'd0);

    $display("[TB] full session");
    stim_q = '{5'b00000, 5'b00110, 5'b01010, 5'b01101, 5'b10010, 5'b10101, 5'b11001, 5'b11111};
    capture_session(1'b0, 0, n);
    drain(1'b0, cyc);
    checkOutput("full_drain_cycles", 32'(cyc), 32'd8);
    checkOutput("full_held_idle", 32'(bus.full), 32'd1);
    checkOutput("count_held_idle", 32'(bus.count), 32'd8);

    $display("[TB] early stop");
    stim_q = '{5'b00110, 5'b11001, 5'b01101};
    capture_session(1'b1, 0, n);
    checkOutput("early_count", 32'(bus.count), 32'd3);
    drain(1'b0, cyc);

    $display("[TB] backpressure");
    stim_q = '{5'b01010, 5'b10010, 5'b00001, 5'b11100, 5'b00111};
    capture_session(1'b1, 1, n);
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("bp_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_vec_held", 32'(bus.out_vec), 32'(5'b01010));
      checkOutput("bp_last", 32'(bus.out_last), 32'd0);
    end
    drain(1'b0, cyc);

    $display("[TB] empty session");
    stim_q = {};
    capture_session(1'b1, 0, n);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("empty_out_valid", 32'(bus.out_valid), 32'd0);
    end

    $display("[TB] overflow");
    stim_q = '{5'b00001, 5'b00010};
    capture_session(1'b1, 0, n);
    checkOutput("ovf_before", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'b11111);
    checkOutput("ovf_set", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("drain_ignores_arm", 32'(bus.busy), 32'd1);
    checkOutput("ovf_count", 32'(bus.count), 32'd2);
    drain(1'b1, cyc);
    checkOutput("ovf_sticky", 32'(bus.overflow), 32'd1);

    $display("[TB] reset mid-drain");
    stim_q = '{5'b10001, 5'b01110, 5'b00011, 5'b11000};
    capture_session(1'b1, 0, n);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    checkOutput("rst_drain_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_drain_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_drain_count", 32'(bus.count), 32'd0);
    checkOutput("rst_drain_full", 32'(bus.full), 32'd0);

    $display("[TB] dedup");
    stim_q = '{5'b10101, 5'b10101, 5'b01101};
    capture_session(1'b1, 0, n);
    checkOutput("dedup_count", 32'(bus.count), 32'(DEDUP_EXP));
    drain(1'b0, cyc);

    $display("[TB] random sessions");
    for (int s = 0; s < 25; s++) begin
      stim_q = {};
      len = $urandom_range(0, 11);
      for (int k = 0; k < len; k++)
        stim_q.push_back((s % 2 == 0) ? VEC_W'($urandom_range(0, 3)) : VEC_W'($urandom));
      capture_session(1'($urandom_range(0, 1)), 2, n);
      drain(1'b1, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
